// File: rtl/param_rotator.sv
// param_rotator: parallel-load word register that applies a programmed
// number of rotate/shift steps, one per clock, with busy/done handshake.
module param_rotator #(
  parameter int WIDTH = 100,
  parameter int AMT_W = 7,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic [1:0]       en,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic [31:0]      rot;
  logic [WIDTH-1:0] rot_l, rot_r;
  logic [WIDTH-1:0] shl, shr, sar;
  logic [WIDTH-1:0] step_val;
  logic             is_rot;
  logic             dir_ok;

  // One step of the captured operation applied to the current word
  always_comb begin
    rot      = 32'(amt_q) % 32'(WIDTH);
    rot_l    = (q_q << rot) | (q_q >> (32'(WIDTH) - rot));
    rot_r    = (q_q >> rot) | (q_q << (32'(WIDTH) - rot));
    shl      = q_q << amt_q;
    shr      = q_q >> amt_q;
    sar      = $unsigned($signed(q_q) >>> amt_q);
    is_rot   = (mode_q == 2'b00) || (mode_q == 2'b11);
    step_val = q_q;
    unique case (1'b1)
      en_q == 2'b01: step_val = is_rot ? rot_l : shl;
      en_q == 2'b10: step_val = is_rot ? rot_r
                              : (mode_q == 2'b10) ? sar : shr;
      default:       step_val = q_q;
    endcase
  end

  assign dir_ok = (en == 2'b01) || (en == 2'b10);

  // Command sequencing: load, accept, step, abort
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    en_d    = en_q;
    mode_d  = mode_q;
    amt_d   = amt_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          q_d = data;
        end else if (start) begin
          en_d   = en;
          mode_d = mode;
          amt_d  = amt;
          if (count == '0 || !dir_ok) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            rem_d   = count;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (load) begin
          q_d     = data;
          busy_d  = 1'b0;
          rem_d   = '0;
          state_d = IDLE;
        end else begin
          q_d   = step_val;
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= '0;
      mode_q  <= '0;
      amt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      amt_q   <= amt_d;
      rem_q   <= rem_d;
    end
  end

  assign q    = q_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/param_rotator.md
# param_rotator

Parametrised rotate/shift register for the shooting-game datapath. It holds a WIDTH-bit word and loads it in parallel. On command it performs a programmable number of rotate or shift operations, one per clock, each by a programmable amount, and signals completion with a busy/done handshake. It replaces the fixed 100-bit, 1-position, edge-triggered rotator and is fully synchronous to a single clock.

## Interface
- WIDTH, 100, width of data word (≥2)
- AMT_W, 7, width of per-step amount field
- CNT_W, 8, width of repeat-count field
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  parallel load strobe, sampled on clk
- data  in  WIDTH  parallel load value
- start  in  1  command strobe, sampled on clk when idle
- en  in  2  direction: 01 left, 10 right, 00/11 no-op
- mode  in  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 rotate (alias)
- amt  in  AMT_W  positions moved per step
- count  in  CNT_W  number of steps
- q  out  WIDTH  register contents
- busy  out  1  high while steps remain
- done  out  1  one-cycle completion pulse

## Operation
- One clock and one synchronous, active-high reset; no other edges are used.
- Reset: q=0, busy=0, done=0, and all captured command fields and the step counter are cleared. Reset overrides every other input.
- States: IDLE, RUN.
- IDLE, load=1: q<=data. A start in the same cycle is ignored, and no done is generated.
- IDLE, start=1, load=0: en, mode, amt and count are captured.
  - If count==0 or en is 00/11: q is unchanged, busy stays 0, and done pulses in the next cycle.
  - Otherwise: busy<=1, remaining<=count, and the state moves to RUN.
- RUN, each cycle: apply one step to q and decrement remaining.
  - On the step where remaining==1: go to IDLE, busy<=0, done<=1.
- RUN, start=1: ignored. Command inputs may change freely; only the captured copies are used.
- RUN, load=1: abort. q<=data, busy<=0, state moves to IDLE, no step is applied and no done is generated.
- Step semantics, with a = captured amt:
  - Rotate: shift by a mod WIDTH; bits leaving one end re-enter at the other.
  - Logical shift: zero fill. a≥WIDTH gives all zeros.
  - Arithmetic shift, right: fill with q[WIDTH-1]. a≥WIDTH gives all copies of the sign bit.
  - Arithmetic shift, left: identical to logical left.
  - a==0: identity step, which still consumes a cycle and a count.
- done is never asserted together with busy.

## Timing
- Command accepted at edge E0. Steps take effect at edges E1…En, with n = count.
- busy is high in the cycles following E0 through En, i.e. for exactly n cycles.
- done is high for the single cycle after En. The final q is visible from En onward.
- Zero-step command: done is high for the single cycle after E0; busy never rises.
- A new start is accepted on the same edge that done is visible (back-to-back issue).
- Load takes effect at the next edge: q=data one cycle after load is sampled.
- Reset asserted during RUN: at the next edge q=0, busy=0, done=0, and the state is IDLE.
- Each step is single-cycle combinational on the current q. Throughput is one step per clock.

## Test plan
Bench parameters WIDTH=8, AMT_W=4, CNT_W=4 unless stated.
- Load 8'hA5; start en=01 mode=00 amt=1 count=1 → q=8'h4B after 1 cycle; busy high 1 cycle; done pulse.
- Load 8'hA5; start en=10 mode=00 amt=3 count=2 → q=8'h96 after 2 cycles; busy high exactly 2 cycles; then done.
- Load 8'h85; start en=10 mode=10 amt=2 count=1 → q=8'hE1. Load 8'hFF; start en=01 mode=01 amt=9 count=1 → q=8'h00. Load 8'hA5; start en=01 mode=00 amt=9 count=1 → q=8'h4B (amount wraps modulo WIDTH).
- Load 8'hA5; start en=01 mode=00 amt=1 count=8; assert load with data=8'h3C after 3 cycles → q=8'h3C; busy drops; no done. Repeat the run, asserting reset instead → q=0, busy=0, done=0.
- Start with count=0, then start with en=11 → each gives a done pulse the next cycle, busy stays 0, q unchanged. Start asserted while busy → ignored.
- Default WIDTH=100: load a random word; start en=01 mode=00 amt=1 count=100 → q equals the loaded word after 100 cycles; done pulses once.
